// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM encoding, the two
// word addresses of the sysid slave, and the timeout counter sizing helper.
package sysid_reader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Counter only has to hold 0..TIMEOUT_CYCLES-1; keep at least one bit.
  function automatic int timeoutCntWidth(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the sysid ID and build timestamp words,
// latches them and reports pass/fail/timeout against the expected values.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          CHECK_TS       = 1'b0,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        pass,
  output logic        timeout
);

  localparam int              CNT_W    = timeoutCntWidth(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_address;
  logic             r_read;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_idValue;
  logic [31:0]      r_tsValue;
  logic             r_idMatch;
  logic             r_tsMatch;
  logic             r_pass;
  logic             r_timeout;

  logic [CNT_W-1:0] w_cntNext;
  logic             w_expire;
  logic             w_idMatch;
  logic             w_tsMatch;

  // The counter reaches TIMEOUT_CYCLES-1 on the edge where w_expire is set;
  // it saturates so an accept on that same edge cannot wrap it.
  always_comb begin
    w_cntNext = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;
    w_expire  = (r_cnt >= CNT_FIRE);
    w_idMatch = (r_idValue == EXPECTED_ID);
    w_tsMatch = (r_tsValue == EXPECTED_TS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_address <= ADDR_ID;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idValue <= '0;
      r_tsValue <= '0;
      r_idMatch <= 1'b0;
      r_tsMatch <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idValue <= '0;
            r_tsValue <= '0;
            r_idMatch <= 1'b0;
            r_tsMatch <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            r_read    <= 1'b1;
            r_address <= ADDR_ID;
            r_cnt     <= '0;
            r_state   <= ID_REQ;
          end
        end

        // Command acceptance wins over a timeout on the same edge; the
        // following WAIT state then expires at once unless data arrives.
        ID_REQ, TS_REQ: begin
          r_cnt <= w_cntNext;
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= (r_state == ID_REQ) ? ID_WAIT : TS_WAIT;
          end else if (w_expire) begin
            r_read    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= FIN;
          end
        end

        ID_WAIT: begin
          if (avm_readdatavalid) begin
            r_idValue <= avm_readdata;
            r_read    <= 1'b1;
            r_address <= ADDR_TS;
            r_cnt     <= '0;
            r_state   <= TS_REQ;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_state   <= FIN;
          end else begin
            r_cnt <= w_cntNext;
          end
        end

        TS_WAIT: begin
          if (avm_readdatavalid) begin
            r_tsValue <= avm_readdata;
            r_state   <= FIN;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_state   <= FIN;
          end else begin
            r_cnt <= w_cntNext;
          end
        end

        FIN: begin
          r_idMatch <= w_idMatch;
          r_tsMatch <= w_tsMatch;
          r_pass    <= w_idMatch && (w_tsMatch || !CHECK_TS) && !r_timeout;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_read    <= 1'b0;
          r_address <= ADDR_ID;
          r_state   <= IDLE;
        end

        default: begin
          r_read  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign avm_address = r_address;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_value    = r_idValue;
  assign ts_value    = r_tsValue;
  assign id_match    = r_idMatch;
  assign ts_match    = r_tsMatch;
  assign pass        = r_pass;
  assign timeout     = r_timeout;

endmodule

// File: doc/sysid_reader.md
Name: sysid_reader

Overview:
- Avalon-MM read master (initiator) for the system-ID responder slave.
- On a start pulse it reads word 0 (system ID) and word 1 (build timestamp), then latches both values.
- It compares them against expected values and reports pass, fail or timeout.
- Sits beside the boot/health logic on the same clock domain as the sysid slave, driving it through the Qsys interconnect.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value word 0 must match.
- EXPECTED_TS, 32'h0000_0000, value word 1 must match when CHECK_TS=1.
- CHECK_TS, 0, 1 = timestamp mismatch fails the check; 0 = timestamp is only captured.
- TIMEOUT_CYCLES, 256, max cycles per read transaction (command issue to readdatavalid); >=2.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a check.
- avm_address  out  1  word address to the sysid slave (0 = ID, 1 = timestamp).
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout).
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.
- id_match  out  1  id_value == EXPECTED_ID.
- ts_match  out  1  ts_value == EXPECTED_TS.
- pass  out  1  id_match && (ts_match || !CHECK_TS) && !timeout.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (clock edge with reset=1): state IDLE; all outputs 0, including avm_read, avm_address, busy, done, both values, all flags and the timeout counter.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- IDLE: start=1 -> ID_REQ next cycle. On the same edge clear id_value, ts_value, id_match, ts_match, pass and timeout, and set busy=1.
- ID_REQ: drive avm_read=1 and avm_address=0, held stable while avm_waitrequest=1. Command is accepted on a cycle with avm_read && !avm_waitrequest; then go to ID_WAIT with avm_read=0 from the next cycle.
- ID_WAIT: on avm_readdatavalid=1, capture avm_readdata into id_value and go to TS_REQ.
- TS_REQ / TS_WAIT: identical, with avm_address=1. The capture goes into ts_value and the next state is FIN.
- FIN (one cycle): compute id_match, ts_match and pass from the registered values; pulse done=1; set busy=0; return to IDLE. Flags and values hold until the next accepted start.
- Earliest completion with a zero-wait, 1-cycle-latency slave: start at cycle 0, done at cycle 6.
- Timeout counter:
  - Cleared on entry to ID_REQ and to TS_REQ; increments every cycle in the REQ and WAIT states.
  - When it reaches TIMEOUT_CYCLES-1 without completing: set timeout=1, drop avm_read the next cycle, go to FIN; pass is then 0.
  - A timeout in ID_* skips the timestamp read.
- Ignored inputs:
  - start while busy or in FIN is ignored; no queuing.
  - avm_readdatavalid outside ID_WAIT/TS_WAIT is ignored; data is not captured.
  - readdatavalid arriving in the same cycle the timeout fires wins: capture and proceed, no timeout.
- Only one outstanding read at a time; avm_read is never asserted in a WAIT state.
- Reset mid-transaction returns to IDLE immediately; a late readdatavalid afterwards is ignored.

Decomposition:
- Package sysid_reader_pkg holds:
  - state enum (6 states, 3-bit encoding);
  - localparams ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - function to compute the timeout counter width, clog2(TIMEOUT_CYCLES).
- No sub-module. The per-transaction timeout counter is small enough to live inline.

Test Plan:
- Slave returns ID 32'hACD51302 and timestamp 32'h528901E6, with waitrequest=0 and readdatavalid one cycle after acceptance; EXPECTED_ID=32'hACD51302, CHECK_TS=1, EXPECTED_TS=32'h528901E6, start at cycle 0 -> done at cycle 6, pass=1, id_match=1, ts_match=1, values captured exactly.
- Same setup but slave ID 32'hACD51303 -> done, id_match=0, pass=0, ts_value still 32'h528901E6.
- waitrequest held high 5 cycles on each command -> avm_address/avm_read stable throughout, exactly two reads accepted, pass=1, done 10 cycles later than the zero-wait case.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid for word 0 -> timeout=1 and done in cycle 9 after start, pass=0, no read issued to address 1.
- start pulsed again while busy, plus a stray readdatavalid in IDLE -> ignored; one done pulse only; values unchanged by the stray data.
- reset asserted during TS_WAIT -> next cycle all outputs 0 and state IDLE; a subsequent start completes a normal pass.
